// File: rtl/sequence_checker.sv
`timescale 1ns/1ps
// sequence_checker
//
// Control stage that sits behind the 16x4 synchronous sequence ROM. It walks
// the ROM in growing rounds (round r replays entries 0..r) and compares each
// entry against a button press. It reports WIN or LOSE to the game FSM.
//
// Optional build macro: SEQUENCE_CHECKER_TIMEOUT_EN
//   defined   -> each press must arrive within TIMEOUT_CYCLES clocks of
//                entering WAIT_PRESS, otherwise LOSE with timeout=1
//   undefined -> no counter; WAIT_PRESS waits forever and timeout stays 0
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   iniciar      start/restart request, sampled only in IDLE/WIN/LOSE
//   botoes       player buttons (synchronised/debounced upstream)
//   rom_data     ROM data_out, valid one clock after rom_address changes
//   rom_address  registered ROM address
//   rodada       current round index
//   pronto       high in WIN or LOSE
//   acertou      high in WIN
//   errou        high in LOSE
//   timeout      high in LOSE when the loss came from the press timer
//   db_estado    state code for the 7-seg debug display
module sequence_checker #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [DATA_W-1:0] botoes,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] rom_address,
    output logic [ADDR_W-1:0] rodada,
    output logic              pronto,
    output logic              acertou,
    output logic              errou,
    output logic              timeout,
    output logic [3:0]        db_estado
);

    // State codes double as the debug display value.
    localparam logic [3:0] ST_IDLE    = 4'h0;
    localparam logic [3:0] ST_PREP    = 4'h1;
    localparam logic [3:0] ST_FETCH   = 4'h2;
    localparam logic [3:0] ST_WAIT    = 4'h3;
    localparam logic [3:0] ST_COMPARE = 4'h4;
    localparam logic [3:0] ST_NEXT    = 4'h5;
    localparam logic [3:0] ST_WIN     = 4'hA;
    localparam logic [3:0] ST_LOSE    = 4'hE;

    localparam logic [ADDR_W-1:0] LAST_ROUND = {ADDR_W{1'b1}};

    logic [3:0]        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] rodada_reg, rodada_next;
    logic [DATA_W-1:0] botoes_q_reg;
    logic [DATA_W-1:0] jogada_reg, jogada_next;
    logic              timeout_reg, timeout_next;

    logic press_event;
    logic jogada_onehot;
    logic terminal_count;

    // A press is only a transition out of "all released"; holding a button
    // across rounds therefore never counts twice.
    assign press_event   = (botoes != '0) && (botoes_q_reg == '0);
    assign jogada_onehot = (jogada_reg != '0) &&
                           ((jogada_reg & (jogada_reg - 1'b1)) == '0);

`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_reg;

    // Held at zero outside WAIT_PRESS so every wait starts from a fresh count.
    // The FSM leaves WAIT_PRESS at the terminal count, so it never wraps.
    always_ff @(posedge clock) begin
        if (reset || (state_reg != ST_WAIT)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign terminal_count = (state_reg == ST_WAIT) &&
                            (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timer the timeout flag can never be set and folds to 0.
    // The parameter is still accepted so both builds share one interface.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign terminal_count     = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        rodada_next  = rodada_reg;
        jogada_next  = jogada_reg;
        timeout_next = timeout_reg;

        case (state_reg)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                // Clearing on the way in keeps PREP showing round 0.
                if (iniciar) begin
                    state_next   = ST_PREP;
                    addr_next    = '0;
                    rodada_next  = '0;
                    timeout_next = 1'b0;
                end
            end
            ST_PREP: begin
                addr_next    = '0;
                rodada_next  = '0;
                timeout_next = 1'b0;
                state_next   = ST_FETCH;
            end
            ST_FETCH: begin
                // ROM captures the address here; data is valid in WAIT_PRESS.
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A press on the terminal count still wins over the timer.
                if (press_event) begin
                    jogada_next = botoes;
                    state_next  = ST_COMPARE;
                end else if (terminal_count) begin
                    timeout_next = 1'b1;
                    state_next   = ST_LOSE;
                end
            end
            ST_COMPARE: begin
                if (!jogada_onehot || (jogada_reg != rom_data)) begin
                    state_next = ST_LOSE;
                end else if (addr_reg < rodada_reg) begin
                    addr_next  = addr_reg + 1'b1;
                    state_next = ST_NEXT;
                end else if (rodada_reg == LAST_ROUND) begin
                    // Checked before any increment so nothing wraps.
                    state_next = ST_WIN;
                end else begin
                    rodada_next = rodada_reg + 1'b1;
                    addr_next   = '0;
                    state_next  = ST_NEXT;
                end
            end
            ST_NEXT: begin
                state_next = ST_FETCH;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            rodada_reg   <= '0;
            botoes_q_reg <= '0;
            jogada_reg   <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            rodada_reg   <= rodada_next;
            botoes_q_reg <= botoes;
            jogada_reg   <= jogada_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign rom_address = addr_reg;
    assign rodada      = rodada_reg;
    assign pronto      = (state_reg == ST_WIN) || (state_reg == ST_LOSE);
    assign acertou     = (state_reg == ST_WIN);
    assign errou       = (state_reg == ST_LOSE);
    assign timeout     = timeout_reg;
    assign db_estado   = state_reg;

endmodule

// File: tb/tb_sequence_checker.sv
`timescale 1ns/1ps
// Bench for sequence_checker: directed scenarios followed by random play,
// all checked every cycle against a game-level model of the checker.
module tb_sequence_checker;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int TO     = 10;

    localparam logic [3:0] C_IDLE  = 4'h0;
    localparam logic [3:0] C_PREP  = 4'h1;
    localparam logic [3:0] C_FETCH = 4'h2;
    localparam logic [3:0] C_WAIT  = 4'h3;
    localparam logic [3:0] C_CMP   = 4'h4;
    localparam logic [3:0] C_NEXT  = 4'h5;
    localparam logic [3:0] C_WIN   = 4'hA;
    localparam logic [3:0] C_LOSE  = 4'hE;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] botoes;
    logic [3:0] rom_data;
    logic [3:0] rom_address;
    logic [3:0] rodada;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int n_press  = 0;

    sequence_checker #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .iniciar(iniciar),
        .botoes(botoes),
        .rom_data(rom_data),
        .rom_address(rom_address),
        .rodada(rodada),
        .pronto(pronto),
        .acertou(acertou),
        .errou(errou),
        .timeout(timeout),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Sequence contents: four entries per one-hot value.
    function automatic logic [3:0] rom_val(input logic [3:0] a);
        logic [3:0] one;
        one = 4'b0001;
        return one << a[3:2];
    endfunction

    always @(posedge clock) rom_data <= rom_val(rom_address);

    // ---------------- game-level reference model ----------------
    typedef struct packed {
        logic [3:0] code;
        logic [3:0] addr;
        logic [3:0] rnd;
        logic       to;
    } exp_t;

    exp_t       cur;
    exp_t       pend[$];
    logic [3:0] m_prev;
    int         m_wait;

    task automatic model_step();
        bit         press;
        logic [3:0] a, r;
        press = (botoes != 4'd0) && (m_prev == 4'd0);
        a = cur.addr;
        r = cur.rnd;
        if (reset) begin
            cur = '0;
            pend.delete();
            m_wait = 0;
        end else if (pend.size() != 0) begin
            cur = pend.pop_front();
            m_wait = 0;
        end else if (cur.code == C_IDLE || cur.code == C_WIN || cur.code == C_LOSE) begin
            if (iniciar) begin
                cur = {C_PREP, 4'd0, 4'd0, 1'b0};
                pend.push_back({C_FETCH, 4'd0, 4'd0, 1'b0});
                pend.push_back({C_WAIT, 4'd0, 4'd0, 1'b0});
            end
        end else if (cur.code == C_WAIT) begin
            if (press) begin
                n_press++;
                $display("press %b round %0d entry %0d want %b", botoes, r, a, rom_val(a));
                cur.code = C_CMP;
                if ($countones(botoes) != 1 || botoes != rom_val(a)) begin
                    pend.push_back({C_LOSE, a, r, 1'b0});
                end else if (a < r) begin
                    pend.push_back({C_NEXT, a + 4'd1, r, 1'b0});
                    pend.push_back({C_FETCH, a + 4'd1, r, 1'b0});
                    pend.push_back({C_WAIT, a + 4'd1, r, 1'b0});
                end else if (r == 4'd15) begin
                    pend.push_back({C_WIN, a, r, 1'b0});
                end else begin
                    pend.push_back({C_NEXT, 4'd0, r + 4'd1, 1'b0});
                    pend.push_back({C_FETCH, 4'd0, r + 4'd1, 1'b0});
                    pend.push_back({C_WAIT, 4'd0, r + 4'd1, 1'b0});
                end
            end
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
            else if (m_wait == TO - 1) begin
                cur = {C_LOSE, a, r, 1'b1};
            end
`endif
            else begin
                m_wait++;
            end
        end
        m_prev = reset ? 4'd0 : botoes;
    endtask

    initial begin
        cur    = '0;
        m_prev = '0;
        m_wait = 0;
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                n_checks++;
                if (db_estado !== cur.code || rom_address !== cur.addr || rodada !== cur.rnd ||
                    pronto !== (cur.code == C_WIN || cur.code == C_LOSE) ||
                    acertou !== (cur.code == C_WIN) || errou !== (cur.code == C_LOSE) ||
                    timeout !== cur.to) begin
                    n_fail++;
                    $display("FAIL cycle @%0t: got st=%h addr=%0d rnd=%0d p/a/e/t=%b%b%b%b, expected st=%h addr=%0d rnd=%0d t=%b",
                             $time, db_estado, rom_address, rodada, pronto, acertou, errou, timeout,
                             cur.code, cur.addr, cur.rnd, cur.to);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    // Advance until the game is waiting for input or has ended.
    task automatic settle(input int limit);
        int n = 0;
        while (!(cur.code inside {C_IDLE, C_WAIT, C_WIN, C_LOSE}) && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (!(cur.code inside {C_IDLE, C_WAIT, C_WIN, C_LOSE})) begin
            n_checks++;
            n_fail++;
            $display("FAIL settle: still in state %h after %0d cycles", cur.code, n);
        end
    endtask

    task automatic press(input logic [3:0] v, input int hold);
        botoes = v;
        repeat (hold) @(negedge clock);
        botoes = 4'd0;
        @(negedge clock);
    endtask

    task automatic press_correct();
        repeat ($urandom_range(0, 2)) @(negedge clock);
        press(rom_val(cur.addr), int'($urandom_range(1, 2)));
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        reset   = 1'b1;
        iniciar = 1'b0;
        botoes  = 4'd0;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        lit("reset db_estado", db_estado, C_IDLE);
        lit("reset pronto", pronto, 0);
        reset = 1'b0;
        @(negedge clock);

        // Full win: every round played correctly.
        p0 = n_press;
        start_game();
        for (int k = 0; k < 200; k++) begin
            settle(20);
            if (cur.code != C_WAIT) break;
            press_correct();
        end
        settle(20);
        lit("win presses", 16'(n_press - p0), 136);
        lit("win acertou", acertou, 1);
        lit("win pronto", pronto, 1);
        lit("win errou", errou, 0);
        lit("win rodada", rodada, 15);
        lit("win db_estado", db_estado, C_WIN);

        // Wrong press in round 0, then restart.
        start_game();
        settle(20);
        press(4'b0010, 1);
        settle(20);
        lit("wrong errou", errou, 1);
        lit("wrong pronto", pronto, 1);
        lit("wrong timeout", timeout, 0);
        lit("wrong db_estado", db_estado, C_LOSE);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        lit("restart db_estado", db_estado, C_PREP);
        lit("restart rodada", rodada, 0);

        // Two buttons at once loses.
        settle(20);
        press(4'b0011, 1);
        settle(20);
        lit("multi db_estado", db_estado, C_LOSE);
        lit("multi errou", errou, 1);

        // Held button: second event only after a release.
        start_game();
        settle(20);
        press_correct();
        settle(20);
        botoes = 4'b0001;
        repeat (8) @(negedge clock);
        lit("held rom_address", rom_address, 1);
        lit("held db_estado", db_estado, C_WAIT);
        botoes = 4'd0;
        @(negedge clock);
        botoes = 4'b0001;
        @(negedge clock);
        botoes = 4'd0;
        settle(20);
        lit("held rodada", rodada, 2);
        lit("held rom_address after", rom_address, 0);

`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
        repeat (TO) @(negedge clock);
        lit("timeout db_estado", db_estado, C_LOSE);
        lit("timeout flag", timeout, 1);
        lit("timeout errou", errou, 1);
        start_game();
        settle(20);
        repeat (TO - 1) @(negedge clock);
        botoes = 4'b0001;
        @(negedge clock);
        botoes = 4'd0;
        lit("last-cycle press db_estado", db_estado, C_CMP);
        lit("last-cycle press timeout", timeout, 0);
`else
        repeat (60) @(negedge clock);
        lit("idle wait db_estado", db_estado, C_WAIT);
        lit("idle wait pronto", pronto, 0);
        lit("idle wait timeout", timeout, 0);
`endif

        // Reset in the middle of round 3.
        for (int k = 0; k < 60; k++) begin
            settle(20);
            if (cur.code != C_WAIT || cur.rnd == 4'd3) break;
            press_correct();
        end
        lit("pre-reset rodada", rodada, 3);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        lit("midreset db_estado", db_estado, C_IDLE);
        lit("midreset rom_address", rom_address, 0);
        lit("midreset rodada", rodada, 0);
        lit("midreset flags", {pronto, acertou, errou, timeout}, 0);

        // Random play, mostly correct presses, with stray iniciar and resets.
        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 599) == 0);
            iniciar = ($urandom_range(0, 9) == 0);
            if (botoes != 4'd0) begin
                if ($urandom_range(0, 9) < 7) botoes = 4'd0;
            end else if ($urandom_range(0, 99) < ((cur.code == C_WAIT) ? 45 : 5)) begin
                if ($urandom_range(0, 9) != 0) botoes = rom_val(cur.addr);
                else botoes = 4'($urandom_range(1, 15));
            end
            @(negedge clock);
        end
        reset   = 1'b0;
        iniciar = 1'b0;
        botoes  = 4'd0;
        repeat (3) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
